// File: rtl/memory_access_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module : memory_access_wb_pkg
// Brief  : Shared widths, field positions and packed request/writeback types.
// Rev    : 1.0  initial release
// ============================================================================
package memory_access_wb_pkg;

  localparam int c_ADDR_W = 8;
  localparam int c_DATA_W = 64;
  localparam int c_REG_AW = 4;

  // ma_in field positions for the default widths
  localparam int c_MA_ADDR_LSB = 0;
  localparam int c_MA_VAL_LSB  = 8;
  localparam int c_MA_REG_LSB  = 72;
  localparam int c_MA_LOAD_BIT = 76;
  localparam int c_MA_MWR_BIT  = 77;
  localparam int c_MA_WR_BIT   = 78;
  localparam int c_MA_W        = 79;

  // wb_bus field positions for the default widths
  localparam int c_WB_REG_LSB = 0;
  localparam int c_WB_VAL_LSB = 4;
  localparam int c_WB_WR_BIT  = 68;
  localparam int c_WB_W       = 69;

  typedef struct packed {
    logic                is_write;
    logic                is_mem_write;
    logic                is_load;
    logic [c_REG_AW-1:0] reg_addr;
    logic [c_DATA_W-1:0] value;
    logic [c_ADDR_W-1:0] address;
  } ma_req_t;

  typedef struct packed {
    logic                is_write;
    logic [c_DATA_W-1:0] value;
    logic [c_REG_AW-1:0] reg_addr;
  } wb_bus_t;

  function automatic int ma_width(input int aw, input int dw, input int rw);
    return aw + dw + rw + 3;
  endfunction

  function automatic int wb_width(input int dw, input int rw);
    return dw + rw + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_access_wb_reg_file.sv
`default_nettype none
// ============================================================================
// Module : reg_file_16x64
// Brief  : Register file, one synchronous write port, one combinational read.
// Rev    : 1.0  initial release
// ============================================================================
module reg_file_16x64
  import memory_access_wb_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int REG_AW = c_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int c_DEPTH = 2 ** REG_AW;

  logic [DATA_W-1:0] r_regs [c_DEPTH];

  // Reset has priority so a write pending on the same edge is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_regs[i_raddr];

endmodule
`default_nettype wire

// File: rtl/memory_access_wb.sv
`default_nettype none
// ============================================================================
// Module : memory_access_wb
// Brief  : Memory-access stage with data memory, MA/WB register and reg file.
//          Optional MEMACC_WB_BYPASS_EN forwards the pending writeback to rd_data.
// Rev    : 1.0  initial release
// ============================================================================
module memory_access_wb
  import memory_access_wb_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W,
  parameter int REG_AW = c_REG_AW
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [ma_width(ADDR_W, DATA_W, REG_AW)-1:0] ma_in,
  output logic [wb_width(DATA_W, REG_AW)-1:0]      wb_bus,
  input  logic [REG_AW-1:0]                        rd_addr,
  output logic [DATA_W-1:0]                        rd_data,
  input  logic [ADDR_W-1:0]                        dm_rd_addr,
  output logic [DATA_W-1:0]                        dm_rd_data
);

  localparam int c_MEM_DEPTH = 2 ** ADDR_W;
  localparam int c_VAL_LSB   = ADDR_W;
  localparam int c_REG_LSB   = ADDR_W + DATA_W;
  localparam int c_LOAD_BIT  = c_REG_LSB + REG_AW;
  localparam int c_MWR_BIT   = c_LOAD_BIT + 1;
  localparam int c_WR_BIT    = c_LOAD_BIT + 2;
  localparam int c_WB_WR_POS = DATA_W + REG_AW;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_value;
  logic [REG_AW-1:0] w_reg;
  logic              w_is_load;
  logic              w_is_mem_write;
  logic              w_is_write;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_wb_next_value;

  logic [DATA_W-1:0] r_mem [c_MEM_DEPTH];
  logic [wb_width(DATA_W, REG_AW)-1:0] r_wb;

  logic              w_wb_we;
  logic [REG_AW-1:0] w_wb_reg;
  logic [DATA_W-1:0] w_wb_value;
  logic [DATA_W-1:0] w_rf_rdata;

  assign w_addr         = ma_in[c_VAL_LSB-1:0];
  assign w_value        = ma_in[c_REG_LSB-1:c_VAL_LSB];
  assign w_reg          = ma_in[c_LOAD_BIT-1:c_REG_LSB];
  assign w_is_load      = ma_in[c_LOAD_BIT];
  assign w_is_mem_write = ma_in[c_MWR_BIT];
  assign w_is_write     = ma_in[c_WR_BIT];

  // Memory has no reset; stores are simply blocked while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && w_is_mem_write) begin
      r_mem[w_addr] <= w_value;
    end
  end

  // Read-before-write: a same-edge store+load forwards the old word
  assign w_load_data     = r_mem[w_addr];
  assign w_wb_next_value = w_is_load ? w_load_data : w_value;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wb <= '0;
    end else begin
      r_wb <= {w_is_write, w_wb_next_value, w_reg};
    end
  end

  assign wb_bus     = r_wb;
  assign w_wb_reg   = r_wb[REG_AW-1:0];
  assign w_wb_value = r_wb[c_WB_WR_POS-1:REG_AW];
  assign w_wb_we    = r_wb[c_WB_WR_POS];

  assign dm_rd_data = r_mem[dm_rd_addr];

  reg_file_16x64 #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wb_we),
    .i_waddr (w_wb_reg),
    .i_wdata (w_wb_value),
    .i_raddr (rd_addr),
    .o_rdata (w_rf_rdata)
  );

`ifdef MEMACC_WB_BYPASS_EN
  assign rd_data = (w_wb_we && (w_wb_reg == rd_addr)) ? w_wb_value : w_rf_rdata;
`else
  assign rd_data = w_rf_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_access_wb.sv
`default_nettype none
// ============================================================================
// Module : tb_memory_access_wb
// Brief  : Directed self-checking bench with a behavioural stage model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_memory_access_wb;
  import memory_access_wb_pkg::*;

  logic          clk;
  logic          rst_n;
  logic [78:0]   ma_in;
  logic [68:0]   wb_bus;
  logic [3:0]    rd_addr;
  logic [63:0]   rd_data;
  logic [7:0]    dm_rd_addr;
  logic [63:0]   dm_rd_data;

  memory_access_wb #(.ADDR_W(8), .DATA_W(64), .REG_AW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ma_in      (ma_in),
    .wb_bus     (wb_bus),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dm_rd_addr (dm_rd_addr),
    .dm_rd_data (dm_rd_data)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [63:0] mem_m [256];
  bit          mem_v [256];
  logic [63:0] reg_m [16];
  wb_bus_t     wb_m;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ma_req_t mk(input logic [7:0] a, input logic [63:0] v, input logic [3:0] r,
                                 input bit ld, input bit mw, input bit wr);
    ma_req_t q;
    q.address = a; q.value = v; q.reg_addr = r;
    q.is_load = ld; q.is_mem_write = mw; q.is_write = wr;
    return q;
  endfunction

  function automatic logic [63:0] exp_rd(input logic [3:0] idx);
`ifdef MEMACC_WB_BYPASS_EN
    if (wb_m.is_write && wb_m.reg_addr == idx) return wb_m.value;
`endif
    return reg_m[idx];
  endfunction

  // Stage semantics: old writeback commits, memory updates, new request captured
  task automatic model_edge(input ma_req_t q, input bit rstn);
    wb_bus_t nxt;
    if (!rstn) begin
      wb_m = '0;
      for (int i = 0; i < 16; i++) reg_m[i] = '0;
      return;
    end
    nxt.is_write = q.is_write;
    nxt.reg_addr = q.reg_addr;
    nxt.value    = q.is_load ? mem_m[q.address] : q.value;
    if (q.is_mem_write) begin
      mem_m[q.address] = q.value;
      mem_v[q.address] = 1'b1;
    end
    if (wb_m.is_write) reg_m[wb_m.reg_addr] = wb_m.value;
    wb_m = nxt;
  endtask

  task automatic step(input ma_req_t q, input bit rstn);
    ma_in = q;
    rst_n = rstn;
    @(posedge clk);
    model_edge(q, rstn);
    #2;
  endtask

  task automatic bubble();
    step(mk(8'h0, 64'h0, 4'h0, 0, 0, 0), 1'b1);
  endtask

  task automatic sweep_regs(input string name);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      check(name, rd_data, exp_rd(4'(i)));
    end
  endtask

  task automatic peek_reg(input string name, input logic [3:0] idx, input logic [63:0] lit);
    rd_addr = idx;
    #1;
    check(name, rd_data, lit);
    check({name, "_model"}, reg_m[idx], lit);
  endtask

  task automatic peek_mem(input string name, input logic [7:0] a, input logic [63:0] lit);
    dm_rd_addr = a;
    #1;
    check(name, dm_rd_data, lit);
    check({name, "_model"}, mem_m[a], lit);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("wb_bus", wb_bus, wb_m);
      check("rd_data", rd_data, exp_rd(rd_addr));
      if (mem_v[dm_rd_addr]) check("dm_rd_data", dm_rd_data, mem_m[dm_rd_addr]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mem_m[i] = '0; mem_v[i] = 1'b0; end
    for (int i = 0; i < 16; i++) reg_m[i] = '0;
    wb_m = '0;
    rst_n = 1'b0; ma_in = '0; rd_addr = '0; dm_rd_addr = '0;

    step(mk(8'h0, 64'h0, 4'h0, 0, 0, 0), 1'b0);
    step(mk(8'h0, 64'h0, 4'h0, 0, 0, 0), 1'b0);
    chk_en = 1'b1;
    check("reset_wb_bus", wb_bus, 69'h0);
    sweep_regs("reset_regs");

    // ALU writeback; mem[0x11] preloaded to prove it is untouched
    step(mk(8'h11, 64'h1111, 4'h0, 0, 1, 0), 1'b1);
    step(mk(8'h11, 64'd5, 4'h6, 0, 0, 1), 1'b1);
    bubble();
    peek_reg("alu_reg6", 4'h6, 64'd5);
    peek_mem("alu_mem11", 8'h11, 64'h1111);

    // Bubble
    bubble();
    check("bubble_wb_we", wb_bus[68], 1'b0);
    sweep_regs("bubble_regs");

    // Store
    step(mk(8'h02, 64'd3, 4'h2, 0, 1, 0), 1'b1);
    bubble();
    peek_mem("store_mem2", 8'h02, 64'd3);
    peek_reg("store_reg2", 4'h2, 64'd0);

    // Load with and without register write
    step(mk(8'h02, 64'h0, 4'h9, 1, 0, 1), 1'b1);
    step(mk(8'h02, 64'h0, 4'hA, 1, 0, 0), 1'b1);
    bubble();
    peek_reg("load_reg9", 4'h9, 64'd3);
    peek_reg("load_nowr_reg10", 4'hA, 64'd0);

    // Same-edge store+load forwards the old word
    step(mk(8'h04, 64'hAA, 4'h0, 0, 1, 0), 1'b1);
    step(mk(8'h04, 64'hBB, 4'hB, 1, 1, 1), 1'b1);
    check("fwd_old_wb_value", wb_bus[67:4], 64'hAA);
    bubble();
    peek_reg("fwd_reg11", 4'hB, 64'hAA);
    peek_mem("fwd_mem4", 8'h04, 64'hBB);

    // Back-to-back store then load
    step(mk(8'h07, 64'h77, 4'h0, 0, 1, 0), 1'b1);
    step(mk(8'h07, 64'h0, 4'hC, 1, 0, 1), 1'b1);
    bubble();
    peek_reg("b2b_reg12", 4'hC, 64'h77);

    // Register 0 and top address are ordinary
    step(mk(8'hFF, 64'hDEAD_BEEF_0123_4567, 4'h0, 0, 1, 1), 1'b1);
    bubble();
    peek_reg("reg0", 4'h0, 64'hDEAD_BEEF_0123_4567);
    peek_mem("mem_ff", 8'hFF, 64'hDEAD_BEEF_0123_4567);

    // Pending write visibility on the read port
    step(mk(8'h0, 64'h55, 4'h5, 0, 0, 1), 1'b1);
    bubble();
    step(mk(8'h0, 64'd7, 4'h5, 0, 0, 1), 1'b1);
    rd_addr = 4'h5;
    #1;
`ifdef MEMACC_WB_BYPASS_EN
    check("bypass_rd5", rd_data, 64'd7);
`else
    check("nobypass_rd5", rd_data, 64'h55);
`endif
    bubble();
    peek_reg("commit_reg5", 4'h5, 64'd7);

    // Reset with a pending write and a suppressed store
    step(mk(8'h0, 64'h66, 4'h6, 0, 0, 1), 1'b1);
    step(mk(8'h02, 64'h99, 4'h0, 0, 1, 0), 1'b0);
    check("rst_wb_bus", wb_bus, 69'h0);
    sweep_regs("rst_regs");
    peek_mem("rst_mem2", 8'h02, 64'd3);
    bubble();
    peek_reg("rst_reg6_dropped", 4'h6, 64'd0);

    bubble();
    bubble();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
